// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter between the fetch port (I) and the
// load/store port (D) onto a single Avalon-MM master. There is one transfer
// at a time, sequenced IDLE -> BUS -> RESP, and every output is registered.
// Optional feature: define ARB_TIMEOUT_EN to abort transfers stalled by
// waitrequest for TIMEOUT_CYCLES cycles. An aborted transfer returns
// 32'hDEAD_BEEF and sets the sticky timeout_err flag.
`timescale 1ns/1ps
module mips_bus_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic        grant_d_q, grant_d_d;   // 1: current transfer belongs to port D
  logic        last_d_q, last_d_d;     // 1: most recent grant went to port D
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  be_q, be_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic        pick_d;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;           // consecutive waitrequest cycles in BUS
  logic        terr_q, terr_d;
`endif

  // Next-state and output-register logic for the IDLE/BUS/RESP sequencer
  always_comb begin
    state_d     = state_q;
    grant_d_d   = grant_d_q;
    last_d_d    = last_d_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = busy_q;
    pick_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    terr_d      = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // D wins when alone, or on a tie when I was granted last
          pick_d    = d_req && (!i_req || !last_d_q);
          grant_d_d = pick_d;
          last_d_d  = pick_d;
          busy_d    = 1'b1;
          state_d   = ST_BUS;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
          if (pick_d) begin
            address_d   = d_addr;
            writedata_d = d_wdata;
            be_d        = d_be;
            read_d      = !d_we;
            write_d     = d_we;
          end else begin
            address_d   = i_addr;
            writedata_d = 32'h0;
            be_d        = 4'b1111;
            read_d      = 1'b1;
            write_d     = 1'b0;
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          // Normal completion; also wins over a timeout in the same cycle
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = ST_RESP;
          if (grant_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = read_q ? readdata : 32'h0;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = readdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TIMEOUT_CYCLES) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          terr_d  = 1'b1;
          state_d = ST_RESP;
          if (grant_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = 32'hDEAD_BEEF;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = 32'hDEAD_BEEF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_d_q   <= 1'b0;
      last_d_q    <= 1'b0;
      address_q   <= 32'h0;
      writedata_q <= 32'h0;
      be_q        <= 4'b0000;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_d_q   <= grant_d_d;
      last_d_q    <= last_d_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = be_q;
  assign read       = read_q;
  assign write      = write_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: stimulus pushes expected bus
// transfers and acks; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic        read, write;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'h0;
  logic        busy, timeout_err;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int len;} bus_t;
  typedef struct {logic port_d; logic [31:0] rdata;} ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  int   checks = 0;
  int   errors = 0;
  int   slave_stalls = 0;
  logic [31:0] slave_rdata = 32'h0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .writedata(writedata), .byteenable(byteenable),
    .read(read), .write(write), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Avalon slave model: stalls each transfer slave_stalls cycles
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (read || write) begin
        if (cnt < slave_stalls) begin
          waitrequest = 1'b1;
          readdata    = 32'hBAD0_BAD0;
          cnt++;
        end else begin
          waitrequest = 1'b0;
          readdata    = slave_rdata;
        end
      end else begin
        cnt         = 0;
        waitrequest = 1'b0;
        readdata    = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: checks bus transfers and acks against the scoreboard queues
  initial begin
    bus_t cur;
    ack_t ea;
    logic prev_strobe = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic [3:0]  prev_be = 4'h0;
    int len = 0;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, -1};
    forever begin
      @(negedge clk);
      if (read && write) chk("one_strobe", 32'(read & write), 32'h0);
      if ((read || write) && !prev_strobe) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 32'(bus_q.size()), 32'h1);
        end else begin
          cur = bus_q.pop_front();
          chk("bus_dir", 32'(write), 32'(cur.we));
          chk("bus_addr", address, cur.addr);
          chk("bus_be", 32'(byteenable), 32'(cur.be));
          if (cur.we) chk("bus_wdata", writedata, cur.wdata);
          chk("bus_busy", 32'(busy), 32'h1);
        end
        len = 1;
      end else if ((read || write) && prev_strobe) begin
        len++;
        chk("bus_stable", {address ^ prev_addr} | {writedata ^ prev_wdata} | 32'(byteenable ^ prev_be), 32'h0);
      end else if (!(read || write) && prev_strobe) begin
        if (cur.len >= 0) chk("bus_len", 32'(len), 32'(cur.len));
      end
      prev_strobe = read || write;
      prev_addr   = address;
      prev_wdata  = writedata;
      prev_be     = byteenable;
      if (i_ack && d_ack) chk("ack_overlap", 32'(i_ack & d_ack), 32'h0);
      if (i_ack || d_ack) begin
        chk("ack_strobes_low", 32'(read | write), 32'h0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 32'(ack_q.size()), 32'h1);
        end else begin
          ea = ack_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(ea.port_d));
          chk("ack_rdata", d_ack ? d_rdata : i_rdata, ea.rdata);
        end
      end
    end
  end

  // One transfer on port I (pd=0) or D (pd=1), with measured latency
  task automatic xfer(input bit pd, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int stalls, input logic [31:0] rdata,
                      input logic [31:0] exp_rdata, input int exp_len, input int exp_lat);
    int lat = 0;
    slave_stalls = stalls;
    slave_rdata  = rdata;
    bus_q.push_back('{we, addr, wdata, (pd ? be : 4'hF), exp_len});
    ack_q.push_back('{pd, exp_rdata});
    if (pd) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      lat++;
      if ((pd && d_ack) || (!pd && i_ack)) break;
    end
    $display("xfer port=%s we=%0d addr=%h stalls=%0d latency=%0d", pd ? "D" : "I", we, addr, stalls, lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_strobes", 32'({read, write}), 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("rst_busy_terr", 32'({busy, timeout_err}), 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_be", 32'(byteenable), 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);

    // Single fetch, no stall
    xfer(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 32'h2402_0005, 32'h2402_0005, 1, 2);
    // Store with 3 stall cycles: strobe 4 cycles, d_rdata 0
    xfer(1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'b0011, 3, 32'h7777_7777, 32'h0, 4, 5);
    chk("i_rdata_hold", i_rdata, 32'h2402_0005);
    chk("d_rdata_write0", d_rdata, 32'h0);
    // Load with one stall and partial byte enables
    xfer(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b1100, 1, 32'h1234_5678, 32'h1234_5678, 2, 3);

    // Reset in the middle of a stalled fetch: no ack, strobes drop
    slave_stalls = 1000;
    bus_q.push_back('{1'b0, 32'hBFC0_0100, 32'h0, 4'hF, -1});
    i_addr = 32'hBFC0_0100;
    i_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    i_req = 1'b0;
    $display("reset mid-BUS read=%0d busy=%0d i_ack=%0d", read, busy, i_ack);
    chk("midrst_read", 32'(read), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ack", 32'({i_ack, d_ack}), 32'h0);
    @(posedge clk); #1;
    chk("midrst_noack", 32'({i_ack, d_ack}), 32'h0);
    xfer(1'b0, 1'b0, 32'hBFC0_0104, 32'h0, 4'hF, 0, 32'h1111_2222, 32'h1111_2222, 1, 2);

    // Contention: both held, last grant was I so D, I, D, I
    slave_stalls = 0;
    slave_rdata  = 32'h0000_00A5;
    bus_q.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'b0110, 1});
    bus_q.push_back('{1'b0, 32'hBFC0_0200, 32'h0, 4'hF, 1});
    bus_q.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'b0110, 1});
    bus_q.push_back('{1'b0, 32'hBFC0_0200, 32'h0, 4'hF, 1});
    repeat (2) begin
      ack_q.push_back('{1'b1, 32'h0000_00A5});
      ack_q.push_back('{1'b0, 32'h0000_00A5});
    end
    d_we = 1'b0; d_addr = 32'h0000_3000; d_be = 4'b0110; i_addr = 32'hBFC0_0200;
    d_req = 1'b1; i_req = 1'b1;
    acks = 0;
    for (int n = 0; n < 40 && acks < 4; n++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) begin
        acks++;
        $display("contention ack %0d port=%s", acks, d_ack ? "D" : "I");
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("contend_acks", 32'(acks), 32'h4);
    @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
    // Boundary: waitrequest drops in the 4th cycle, normal completion
    xfer(1'b0, 1'b0, 32'hBFC0_0300, 32'h0, 4'hF, 3, 32'h0BD0_0001, 32'h0BD0_0001, 4, 5);
    chk("boundary_terr", 32'(timeout_err), 32'h0);
    // Timeout: stall forever, abort after 4 cycles
    xfer(1'b0, 1'b0, 32'hBFC0_0304, 32'h0, 4'hF, 100, 32'h5555_AAAA, 32'hDEAD_BEEF, 4, 5);
    chk("timeout_terr", 32'(timeout_err), 32'h1);
    xfer(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 32'h0000_0042, 32'h0000_0042, 1, 2);
    chk("terr_sticky", 32'(timeout_err), 32'h1);
`else
    chk("terr_tied0", 32'(timeout_err), 32'h0);
`endif

    for (int n = 0; n < 20 && (bus_q.size() != 0 || ack_q.size() != 0); n++) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port arbiter and sequencer placed between the CPU core's instruction-fetch and data-access paths and the single Avalon memory-mapped master bus. It accepts independent requests from the fetch unit (port I) and the load/store unit (port D), grants one at a time, and drives the Avalon handshake including `waitrequest` stalls. It returns a single-cycle acknowledge with registered read data to the granted requester.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum consecutive `waitrequest` cycles before a transfer is aborted. Only used with `ARB_TIMEOUT_EN`; width 8 bits; legal range 1..255.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ack`.
- `i_addr`  in  32  fetch byte address; read-only port, `byteenable` is always 4'b1111.
- `i_ack`  out  1  one-cycle pulse when the fetch completes.
- `i_rdata`  out  32  fetched word; valid while `i_ack` is high.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_be`  in  4  store/load byte enables.
- `d_ack`  out  1  one-cycle pulse when the data transfer completes.
- `d_rdata`  out  32  load word; valid while `d_ack` is high; 0 for writes.
- `address`, `writedata`  out  32  Avalon master address and write data.
- `byteenable`  out  4  Avalon byte enables.
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  Avalon slave stall.
- `readdata`  in  32  Avalon read data; valid in the cycle a read completes.
- `busy`  out  1  high in the BUS and RESP states.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - If any request is pending, select a winner, latch its address, data, byte enables and direction into output registers, record the grant, and go to BUS.
  - With no request, stay in IDLE.
- Arbitration when both requesters are pending: the port not granted last wins (round-robin). With a single requester, that port wins. `last_grant` resets to I, so D wins the first tie.
- BUS:
  - Exactly one of `read`/`write` is high.
  - `address`, `writedata` and `byteenable` are held constant while `waitrequest` is high.
  - The transfer completes on the first edge where `waitrequest` is low.
  - On a read, `readdata` is captured into the granted port's rdata register.
  - On completion, go to RESP.
- RESP:
  - `read` and `write` are low.
  - The granted port's ack is high for exactly this cycle. The other ack stays low.
  - Requests are ignored in this cycle.
  - Always go to IDLE next.
- The requester must deassert `req` or present a new request on the edge ending RESP. A `req` still high in IDLE is treated as a new request.
- Changing request fields while a transfer is outstanding has no effect on it, because they are latched in IDLE.
- `d_rdata` is 32'h0 after a write. `i_rdata`/`d_rdata` hold their value until that port's next completion.
- Reset values:
  - state = IDLE.
  - `read`, `write`, `i_ack`, `d_ack`, `busy`, `timeout_err` = 0.
  - `address`, `writedata`, `i_rdata`, `d_rdata` = 0.
  - `byteenable` = 4'b0000.
- Reset mid-transfer: the strobes drop on the reset edge, no ack is issued, and the transfer is abandoned.

## Timing
- Minimum latency: `req` sampled in IDLE at edge 0 → strobe high in cycle 1 → ack high in cycle 2.
- Each `waitrequest` cycle adds one cycle of latency.
- Peak throughput: one transfer per 3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- No back-to-back grants: there is always one RESP cycle and one IDLE cycle between transfers.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle with `waitrequest` high.
  - When the counter reaches `TIMEOUT_CYCLES` with `waitrequest` still high, the strobes drop and the FSM goes to RESP.
  - The ack is issued with rdata = 32'hDEAD_BEEF, and `timeout_err` is set; it is sticky until reset.
  - A `waitrequest` low in that same cycle is a normal completion and takes priority over the timeout.
- `ARB_TIMEOUT_EN` undefined:
  - The block waits indefinitely on `waitrequest`.
  - `timeout_err` is tied to 0 and the counter is not built.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=32'hBFC0_0000, `waitrequest`=0, `readdata`=32'h2402_0005 → `read`=1 with that address in cycle 1; `i_ack`=1 with `i_rdata`=32'h2402_0005 in cycle 2.
- Store with stall: `d_req`, `d_we`=1, `d_addr`=32'h0000_1000, `d_wdata`=32'hCAFE_F00D, `d_be`=4'b0011, `waitrequest` high for 3 cycles → `write` and all fields stable for 4 cycles; `d_ack` 1 cycle later; `d_rdata`=0.
- Contention: `i_req` and `d_req` both held continuously → grants alternate D, I, D, I; no ack overlap; exactly one strobe active at any time.
- Reset mid-BUS: reset asserted during a read with `waitrequest`=1 → next cycle `read`=0, no ack, state IDLE; a fresh request then completes normally.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): `waitrequest` held at 1 → after 4 stall cycles the strobe drops; ack with rdata 32'hDEAD_BEEF; `timeout_err`=1 and stays set.
- Timeout boundary: `waitrequest` drops in the 4th cycle → normal completion with real `readdata`; `timeout_err` stays 0.
